// File: rtl/fifosync_reader.sv
// ---------------------------------------------------------------------------
// fifosync_reader
//
// Read-side adapter for the synchronous FIFO. It issues FIFO reads, absorbs
// the one-cycle read latency in a 3-entry buffer, and presents the data as a
// valid/ready stream framed into bursts of BURST beats.
//
// Parameters
//   DW     data width, must match the attached FIFO
//   BURST  beats per burst (>= 1); out_last marks beat BURST-1
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   fifo_rd_en     read request to the FIFO
//   fifo_rd_data   FIFO read data, valid with fifo_rd_valid
//   fifo_rd_valid  FIFO read strobe, one cycle after an accepted read
//   fifo_empty     FIFO empty flag
//   out_valid      output beat available
//   out_ready      consumer accepts the beat when out_valid && out_ready
//   out_data       head-of-buffer data
//   out_last       final beat of the current burst, qualified by out_valid
//   level          buffer occupancy, 0..3
// ---------------------------------------------------------------------------
module fifosync_reader #(
  parameter int DW    = 16,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  input  logic          fifo_rd_valid,
  input  logic          fifo_empty,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    level
);

  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);
  localparam int DEPTH = 3;

  // Pointer state; pointers only take the values 0, 1, 2.
  logic [1:0]     head_reg, head_next;
  logic [1:0]     tail_reg, tail_next;
  logic [1:0]     occ_reg, occ_next;
  logic           inflight_reg;
  logic [BCW-1:0] beat_cnt_reg, beat_cnt_next;

  logic capture;
  logic pop;
  logic [2:0] committed;

  // Three-way wrap of a buffer pointer.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A strobe only counts when we know a read of ours is outstanding; the
  // FIFO's strobe register is not cleared by reset, so a stray strobe right
  // after reset must not land in the buffer.
  assign capture = inflight_reg && fifo_rd_valid;
  assign pop     = out_valid && out_ready;

  // Slots already holding data plus the one that will arrive next cycle.
  // Counting the outstanding read keeps the buffer from overflowing, and the
  // decision uses registered state only so out_ready never reaches rd_en.
  assign committed  = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign fifo_rd_en = !rst && !fifo_empty && (committed < 3'd3);

  // ---------------------------------------------------------------------
  // Buffer storage: one register per entry, written at the tail on capture.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DW-1:0] data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (capture && (tail_reg == 2'(gi))) begin
          data_reg <= fifo_rd_data;
        end
      end
    end
  endgenerate

  // Head-of-buffer read mux.
  always_comb begin
    out_data = g_entry[0].data_reg;
    case (head_reg)
      2'd1:    out_data = g_entry[1].data_reg;
      2'd2:    out_data = g_entry[2].data_reg;
      default: out_data = g_entry[0].data_reg;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pointer, occupancy and burst-framing next-state logic.
  // ---------------------------------------------------------------------
  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    occ_next      = occ_reg;
    beat_cnt_next = beat_cnt_reg;

    if (capture) begin
      tail_next = ptr_inc(tail_reg);
    end

    if (pop) begin
      head_next = ptr_inc(head_reg);
      if (beat_cnt_reg == LAST_BEAT) begin
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt_reg + BCW'(1);
      end
    end

    // Capture and pop together leave the occupancy unchanged.
    case ({capture, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= 2'd0;
      tail_reg     <= 2'd0;
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      beat_cnt_reg <= '0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      occ_reg      <= occ_next;
      inflight_reg <= fifo_rd_en;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign out_valid = (occ_reg != 2'd0);
  assign out_last  = out_valid && (beat_cnt_reg == LAST_BEAT);
  assign level     = occ_reg;

endmodule

// File: tb/tb_fifosync_reader.sv
// ---------------------------------------------------------------------------
// tb_fifosync_reader
//
// Self-checking bench for fifosync_reader (DW=16, BURST=4). A queue stands in
// for the FIFO; a second queue holds the words the adapter has taken from the
// FIFO but not yet delivered. Every cycle the outputs are compared with what
// those queues and a running beat count imply.
// ---------------------------------------------------------------------------
module tb_fifosync_reader;

  localparam int DW    = 16;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_valid = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    level;

  fifosync_reader #(.DW(DW), .BURST(BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_valid(fifo_rd_valid),
    .fifo_empty   (fifo_empty),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .level        (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fq[$];     // FIFO contents
  logic [DW-1:0] dq[$];     // taken from FIFO, not yet delivered
  logic [DW-1:0] acc_d[$];  // accepted beats (data)
  bit            acc_l[$];  // accepted beats (last flag)
  logic [DW-1:0] wq[$];     // words pushed in the current phase

  bit pend   = 1'b0;  // a read was issued last cycle
  bit synced = 1'b0;  // a reset edge has been observed
  bit stray  = 1'b0;  // drive one unsolicited rd_valid next cycle
  int beats     = 0;  // beats accepted since reset
  int cyc_n     = 0;
  int rd_cnt    = 0;
  int first_rd  = -1;
  int first_vld = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    wq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, update the model at
  // the rising edge, then drive the FIFO side for the next cycle.
  task automatic cyc();
    logic          rd_o, v_o, l_o, hs;
    logic [DW-1:0] d_o;
    logic [1:0]    lv_o;
    bit            exp_rd;
    @(negedge clk);
    rd_o = fifo_rd_en;
    v_o  = out_valid;
    l_o  = out_last;
    d_o  = out_data;
    lv_o = level;
    exp_rd = !rst && !fifo_empty && ((dq.size() + int'(pend)) < 3);
    chk("rd_en", 32'(rd_o), 32'(exp_rd));
    if (synced) begin
      chk("level", 32'(lv_o), 32'(dq.size()));
      chk("out_valid", 32'(v_o), 32'(dq.size() != 0));
      if (dq.size() != 0) begin
        chk("out_data", 32'(d_o), 32'(dq[0]));
        chk("out_last", 32'(l_o), 32'((beats % BURST) == BURST - 1));
      end else begin
        chk("out_last_idle", 32'(l_o), 32'd0);
      end
    end
    if (rd_o === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc_n;
    end
    if (v_o === 1'b1 && first_vld < 0) first_vld = cyc_n;
    hs = (v_o === 1'b1) && out_ready;
    if (hs) begin
      acc_d.push_back(d_o);
      acc_l.push_back(l_o);
      $display("[TB] cycle %0d beat data=0x%04h last=%0d level=%0d", cyc_n, d_o, l_o, lv_o);
    end
    @(posedge clk);
    if (rst) begin
      dq.delete();
      beats  = 0;
      pend   = 1'b0;
      synced = 1'b1;
    end else begin
      if (hs && dq.size() > 0) begin
        void'(dq.pop_front());
        beats++;
      end
      if (pend && fifo_rd_valid) dq.push_back(fifo_rd_data);
      pend = (rd_o === 1'b1);
    end
    #1;
    cyc_n++;
    if (rd_o === 1'b1 && fq.size() > 0) begin
      fifo_rd_data  = fq.pop_front();
      fifo_rd_valid = 1'b1;
    end else begin
      fifo_rd_data  = DW'($urandom);
      fifo_rd_valid = stray;
      stray = 1'b0;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((fq.size() != 0 || dq.size() != 0 || pend) && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(fq.size() + dq.size() + int'(pend)), 32'd0);
  endtask

  // Compare the accepted log with the pushed words and the expected framing.
  task automatic check_log(input string tag, input int base);
    chk({tag, "_count"}, 32'(acc_d.size()), 32'(wq.size()));
    for (int i = 0; i < acc_d.size() && i < wq.size(); i++) begin
      chk({tag, "_data"}, 32'(acc_d[i]), 32'(wq[i]));
      chk({tag, "_last"}, 32'(acc_l[i]), 32'(((base + i) % BURST) == BURST - 1));
    end
  endtask

  task automatic new_phase();
    acc_d.delete();
    acc_l.delete();
    wq.delete();
    rd_cnt    = 0;
    first_rd  = -1;
    first_vld = -1;
  endtask

  initial begin
    int base;
    int n;
    int e_cyc;

    // ---- Reset with the FIFO holding data -------------------------------
    new_phase();
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("rst_first_rd", 32'(rd_cnt), 32'd1);
    drain(40);
    check_log("rst_drain", 0);

    // ---- Streaming 0x0001..0x0008 ---------------------------------------
    new_phase();
    base = beats;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    drain(40);
    chk("stream_latency", 32'(first_vld - first_rd), 32'd2);
    check_log("stream", base);

    // ---- Backpressure with 10 words -------------------------------------
    new_phase();
    base = beats;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(DW'($urandom));
    for (int i = 0; i < 8; i++) cyc();
    chk("bp_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("bp_level", 32'(level), 32'd3);
    chk("bp_head", 32'(out_data), 32'(wq[0]));
    out_ready = 1'b1;
    drain(60);
    check_log("bp", base);

    // ---- Toggling ready over 12 words -----------------------------------
    new_phase();
    base = beats;
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    n = 0;
    while ((fq.size() != 0 || dq.size() != 0 || pend) && n < 100) begin
      out_ready = (n % 2 == 0);
      cyc();
      n++;
    end
    out_ready = 1'b1;
    drain(20);
    check_log("toggle", base);

    // ---- Reset mid-burst with a stray strobe ----------------------------
    new_phase();
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    base = beats;
    n = 0;
    while (!(beats > base && (beats % BURST) == 2) && n < 40) begin
      cyc();
      n++;
    end
    chk("midrst_reached", 32'(beats % BURST), 32'd2);
    rst = 1'b1;
    fq.delete();
    fifo_empty = 1'b1;
    stray = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("stray_level", 32'(level), 32'd0);
    chk("stray_valid", 32'(out_valid), 32'd0);
    new_phase();
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    drain(30);
    check_log("after_rst", 0);

    // ---- Empty then refill ----------------------------------------------
    new_phase();
    base = beats;
    for (int i = 0; i < 5; i++) cyc();
    chk("empty_no_rd", 32'(rd_cnt), 32'd0);
    push(DW'($urandom));
    e_cyc = cyc_n;
    drain(20);
    chk("refill_latency", 32'(first_vld - e_cyc), 32'd2);
    check_log("refill", base);

    // ---- Randomised traffic ---------------------------------------------
    new_phase();
    base = beats;
    for (int i = 0; i < 200; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && fq.size() < 20) push(DW'($urandom));
      cyc();
    end
    out_ready = 1'b1;
    drain(100);
    check_log("random", base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifosync_reader.md
# fifosync_reader

Read-side adapter for the team's synchronous FIFO. It drives the FIFO read port (rd_en, rd_data, rd_valid, empty) and converts it into a valid/ready output stream with burst framing. A 3-entry output buffer absorbs the FIFO's one-cycle read latency, so the block sustains one beat per cycle under continuous out_ready. It sits between a fifosync instance and any downstream ready/valid consumer.

## Interface
- DW, 16: data width; must match the attached FIFO.
- BURST, 4: beats per burst; out_last marks beat BURST-1 of each burst; BURST >= 1.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_rd_en  out  1  read request to the FIFO.
- fifo_rd_data  in  DW  FIFO read data, valid when fifo_rd_valid=1.
- fifo_rd_valid  in  1  FIFO read-data strobe, one cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  output beat available.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_data  out  DW  head-of-buffer data.
- out_last  out  1  final beat of the current burst; qualified by out_valid.
- level  out  2  buffer occupancy, 0..3.

## Operation
- State:
  - 3-entry buffer with head and tail pointers, each 2 bits, wrapping 2 -> 0.
  - occ: 2 bits, 0..3.
  - inflight: 1 bit, set to fifo_rd_en of the previous cycle.
  - beat_cnt: max(1, clog2(BURST)) bits, 0..BURST-1.
- Read issue: fifo_rd_en = !rst && !fifo_empty && (occ + inflight < 3).
  - Depends only on registered state and fifo_empty; there is no combinational path from out_ready.
- Capture: when inflight=1 && fifo_rd_valid=1, write fifo_rd_data at tail and advance tail.
  - fifo_rd_valid with inflight=0 is ignored. This covers the FIFO's rd_valid, which is not cleared by reset.
- Pop: when out_valid && out_ready, advance head.
- Occupancy: occ += capture - pop. Simultaneous capture and pop leaves occ unchanged. Capture is never issued when the buffer would overflow (guaranteed by the issue rule).
- Output signals:
  - out_valid = (occ != 0).
  - out_data = buffer[head].
  - level = occ.
- Burst framing:
  - beat_cnt increments on each pop and wraps to 0 on the pop of the BURST-1 beat.
  - out_last = out_valid && (beat_cnt == BURST-1). With BURST=1, every beat is last.
- Order: strictly FIFO. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Reset values:
  - fifo_rd_en=0, out_valid=0, out_last=0, out_data=0 (buffer cleared), level=0.
  - head=tail=0, inflight=0, beat_cnt=0.
- Reset mid-operation: all state is discarded on the next edge, and the partial burst is abandoned. After reset, framing restarts at beat 0.
- Latency:
  - fifo_rd_en in cycle t; data captured at the end of t+1; out_valid first high in t+2.
  - So, from fifo_empty falling on an idle block to out_valid is 2 cycles.
- Throughput: with out_ready held at 1 and the FIFO non-empty, steady state is occ=1, inflight=1, one rd_en and one beat per cycle.
- Backpressure: with out_ready=0, at most 3 reads are issued, then fifo_rd_en stays 0 with level=3. Once out_ready rises, the first new rd_en occurs in the cycle after the first pop.
- FIFO empty: no rd_en is issued. Buffered beats continue to drain.

## Test plan
- Reset: assert rst for 2 cycles with the FIFO holding data -> fifo_rd_en, out_valid, out_last and level all 0 during reset; first rd_en in the cycle after deassert.
- Streaming, BURST=4: push 0x0001..0x0008, out_ready=1 -> first out_valid 2 cycles after the first rd_en; 8 consecutive beats 0x0001..0x0008; out_last on 0x0004 and 0x0008 only.
- Backpressure: 10 words in the FIFO, out_ready=0 -> exactly 3 fifo_rd_en pulses, level=3, out_data=first word. Then set out_ready=1 -> all 10 words out in order, none lost.
- Toggling ready: out_ready alternates 1,0 over 12 words -> output in order, level never exceeds 3, out_last every 4th accepted beat.
- Reset mid-burst: reset after 2 beats of a burst while fifo_rd_valid is forced high for one cycle after reset -> the stray strobe is ignored (level stays 0); the next accepted 4 beats end with out_last on the 4th.
- Empty/refill: FIFO drains fully, then one word is written 5 cycles later -> no rd_en while empty; a single beat appears 2 cycles after fifo_empty falls, with out_last per beat_cnt.
